scene_line_clear: RTL and testbench
===================================

SCENE_LINE_CLEAR -- requirements
Module: scene_line_clear

Interface
REQ-001 Parameter width_p, default 16: scene columns, 4..64.
REQ-002 Parameter height_p, default 32: scene rows, 4..64; row 0 = top, row height_p-1 = bottom.
REQ-003 Parameter total_w_p, default 16: width of the lifetime line counter.
REQ-004 Port clk_i input 1: single clock; all state on the rising edge.
REQ-005 Port reset_n_i input 1: asynchronous assert, active-low reset.
REQ-006 Port clear_v_i input 1: request to wipe the scene and the lifetime counter.
REQ-007 Port commit_v_i input 1: commit request.
REQ-008 Port commit_shape_i input 16: 4x4 shape; bit [i][j] maps to row y+i, column x+j.
REQ-009 Port commit_x_i input $clog2(width_p)+1: signed anchor column, two's complement.
REQ-010 Port commit_y_i input $clog2(height_p)+1: signed anchor row, two's complement.
REQ-011 Port commit_ready_o output 1: commit accepted this cycle if commit_v_i is high.
REQ-012 Port commit_overlap_o output 1: registered pulse; the last accepted commit hit an occupied cell.
REQ-013 Port check_v_i input 1: request a full-row scan and clear.
REQ-014 Port check_ready_o output 1: check accepted this cycle if check_v_i is high.
REQ-015 Port done_v_o output 1: one-cycle pulse at the end of a check.
REQ-016 Port cleared_cnt_o output $clog2(height_p+1): rows cleared by the last check; held until the next check completes.
REQ-017 Port total_lines_o output total_w_p: saturating lifetime count of cleared rows.
REQ-018 Port busy_o output 1: high in any state other than IDLE.
REQ-019 Port rd_row_i input $clog2(height_p): renderer row select.
REQ-020 Port rd_data_o output width_p: combinational scene row rd_row_i, current contents (mid-shift included); 0 if rd_row_i >= height_p.

Function
REQ-021 FSM states: IDLE, SCAN, SHIFT, DONE.
REQ-022 Priority in IDLE: clear_v_i > commit_v_i > check_v_i; only one request is taken per cycle.
REQ-023 The wipe is taken in IDLE only: scene and total_lines_o go to 0 at the edge; state stays IDLE; clear_v_i is ignored outside IDLE.
REQ-024 commit_ready_o = IDLE & !clear_v_i.
REQ-025 check_ready_o = IDLE & !clear_v_i & !commit_v_i.
REQ-026 Commit write: at the accept edge, each set shape bit is ORed into its target cell; state stays IDLE.
REQ-027 Commit bounds: cells with row or column outside [0,height_p-1]/[0,width_p-1] are dropped silently.
REQ-028 Overlap flag: commit_overlap_o is 1 in the cycle after an accepted commit where any in-bounds set bit hit an occupied cell, else 0; the write still occurs.
REQ-029 Check accept: IDLE->SCAN; row pointer r = height_p-1; per-check count = 0.
REQ-030 SCAN, row r all ones: ->SHIFT.
REQ-031 SCAN, row r not full and r>0: r decrements; stays SCAN.
REQ-032 SCAN, row r not full and r==0: ->DONE.
REQ-033 SHIFT, one cycle: row k takes row k-1 for k=r..1; row 0 = 0; count increments; ->SCAN with r unchanged.
REQ-034 DONE: done_v_o=1; cleared_cnt_o loads the count; total_lines_o adds it, saturating at 2^total_w_p-1; ->IDLE.
REQ-035 Latency: accept at cycle 0, with k rows cleared, places done_v_o exactly at cycle height_p+2k+1.
REQ-036 Commits and checks are not accepted while busy_o=1; requests are not queued.

Reset
REQ-037 While reset_n_i=0: state IDLE, scene all zero, r=height_p-1, cleared_cnt_o=0, total_lines_o=0, done_v_o=0, commit_overlap_o=0, busy_o=0.
REQ-038 Reset mid-check: the check is abandoned with no done_v_o pulse; all values are as in REQ-037.

Verification
REQ-039 Commit T shape (row0=0111, row1=0010), x=2, y=30, default params -> rd_data_o row 30 = 0x001C (cols 2-4), row 31 = 0x0008, commit_overlap_o=0; same commit repeated -> commit_overlap_o=1, scene unchanged.
REQ-040 Commit with x=-1, y=-2, full 0xFFFF shape -> only rows 0-1, cols 0-2 are set; no error.
REQ-041 Rows 31 and 29 full, row 30 = 0x0001, row 28 = 0x8000, check -> done_v_o at cycle 37, cleared_cnt_o=2, row 31=0x0001, row 30=0x8000, rows 0-29 zero, total_lines_o=2.
REQ-042 Empty scene check -> done_v_o at cycle 33, cleared_cnt_o=0; commit_v_i and check_v_i asserted together in IDLE -> commit taken, check_ready_o=0.
REQ-043 total_w_p=2, total_lines_o=3 preset via checks, then clear one more row -> total_lines_o stays 3; clear_v_i -> total_lines_o=0 and all rows 0.
REQ-044 reset_n_i pulsed low at cycle 10 of a check -> busy_o=0 immediately, no done_v_o pulse, scene all zero.

Source files
------------

// File: rtl/scene_line_clear.sv
`timescale 1ns/1ps
// scene_line_clear: bit-mapped playfield that takes 4x4 shape commits, scans
// bottom-up for full rows, collapses them one at a time, and keeps a
// saturating lifetime count of cleared rows. The renderer reads rows
// combinationally.
module scene_line_clear #(
  parameter int width_p   = 16,
  parameter int height_p  = 32,
  parameter int total_w_p = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          clear_v_i,
  input  logic                          commit_v_i,
  input  logic [15:0]                   commit_shape_i,
  input  logic [$clog2(width_p):0]      commit_x_i,
  input  logic [$clog2(height_p):0]     commit_y_i,
  output logic                          commit_ready_o,
  output logic                          commit_overlap_o,
  input  logic                          check_v_i,
  output logic                          check_ready_o,
  output logic                          done_v_o,
  output logic [$clog2(height_p+1)-1:0] cleared_cnt_o,
  output logic [total_w_p-1:0]          total_lines_o,
  output logic                          busy_o,
  input  logic [$clog2(height_p)-1:0]   rd_row_i,
  output logic [width_p-1:0]            rd_data_o
);

  localparam int RW = $clog2(height_p);
  localparam int CW = $clog2(width_p);
  localparam int NW = $clog2(height_p + 1);
  // Sum width wide enough that neither operand can wrap before saturation.
  localparam int SW = ((total_w_p > NW) ? total_w_p : NW) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_e;

  state_e                 state_q, state_d;
  logic [width_p-1:0]     scene_q [height_p];
  logic [width_p-1:0]     scene_d [height_p];
  logic [RW-1:0]          row_q, row_d;
  logic [NW-1:0]          cnt_q, cnt_d;
  logic [NW-1:0]          cleared_q, cleared_d;
  logic [total_w_p-1:0]   total_q, total_d;
  logic                   overlap_q, overlap_d;
  logic [SW-1:0]          sat_sum;

  assign sat_sum = SW'(total_q) + SW'(cnt_q);

  // Handshake and status outputs decoded straight from the state register.
  assign commit_ready_o   = (state_q == IDLE) & ~clear_v_i;
  assign check_ready_o    = (state_q == IDLE) & ~clear_v_i & ~commit_v_i;
  assign done_v_o         = (state_q == DONE);
  assign busy_o           = (state_q != IDLE);
  assign commit_overlap_o = overlap_q;
  assign cleared_cnt_o    = cleared_q;
  assign total_lines_o    = total_q;

  // Renderer port: live scene row, zero for rows past the bottom.
  always_comb begin
    rd_data_o = '0;
    if (int'(rd_row_i) < height_p) rd_data_o = scene_q[rd_row_i];
  end

  // Next-state logic: request arbitration in IDLE, bottom-up scan, one-row collapse.
  always_comb begin
    int ty;
    int tx;
    state_d   = state_q;
    scene_d   = scene_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    cleared_d = cleared_q;
    total_d   = total_q;
    overlap_d = 1'b0;
    ty        = 0;
    tx        = 0;
    case (state_q)
      IDLE: begin
        if (clear_v_i) begin
          for (int k = 0; k < height_p; k++) scene_d[RW'(k)] = '0;
          total_d = '0;
        end else if (commit_v_i) begin
          // Shape bit i*4+j lands at (y+i, x+j); off-scene cells are dropped.
          for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
              ty = int'($signed(commit_y_i)) + i;
              tx = int'($signed(commit_x_i)) + j;
              if (commit_shape_i[4'(i * 4 + j)] && ty >= 0 && ty < height_p &&
                  tx >= 0 && tx < width_p) begin
                if (scene_q[RW'(ty)][CW'(tx)]) overlap_d = 1'b1;
                scene_d[RW'(ty)][CW'(tx)] = 1'b1;
              end
            end
          end
        end else if (check_v_i) begin
          state_d = SCAN;
          row_d   = RW'(height_p - 1);
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (&scene_q[row_q]) begin
          state_d = SHIFT;
        end else if (row_q != '0) begin
          row_d = row_q - 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      SHIFT: begin
        // Everything above the full row drops by one; the same row is rescanned.
        for (int k = 1; k < height_p; k++) begin
          if (k <= int'(row_q)) scene_d[RW'(k)] = scene_q[RW'(k - 1)];
        end
        scene_d[0] = '0;
        cnt_d      = cnt_q + NW'(1);
        state_d    = SCAN;
      end
      DONE: begin
        cleared_d = cnt_q;
        if (sat_sum > SW'({total_w_p{1'b1}})) total_d = '1;
        else                                   total_d = sat_sum[total_w_p-1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any check in flight and wipes everything.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      scene_q   <= '{default: '0};
      row_q     <= RW'(height_p - 1);
      cnt_q     <= '0;
      cleared_q <= '0;
      total_q   <= '0;
      overlap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      scene_q   <= scene_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      cleared_q <= cleared_d;
      total_q   <= total_d;
      overlap_q <= overlap_d;
    end
  end

endmodule

// File: tb/tb_scene_line_clear.sv
`timescale 1ns/1ps
// Bench for scene_line_clear: table of shape commits checked against a
// reference playfield, plus check / clear / reset sequences.
module tb_scene_line_clear;

  localparam int W    = 16;
  localparam int H    = 32;
  localparam int TW   = 2;
  localparam int TMAX = 3;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        clear_v_i;
  logic        commit_v_i;
  logic [15:0] commit_shape_i;
  logic [4:0]  commit_x_i;
  logic [5:0]  commit_y_i;
  logic        commit_ready_o;
  logic        commit_overlap_o;
  logic        check_v_i;
  logic        check_ready_o;
  logic        done_v_o;
  logic [5:0]  cleared_cnt_o;
  logic [1:0]  total_lines_o;
  logic        busy_o;
  logic [4:0]  rd_row_i;
  logic [15:0] rd_data_o;

  always #5 clk_i = ~clk_i;

  scene_line_clear #(.width_p(W), .height_p(H), .total_w_p(TW)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_v_i(clear_v_i),
    .commit_v_i(commit_v_i), .commit_shape_i(commit_shape_i),
    .commit_x_i(commit_x_i), .commit_y_i(commit_y_i),
    .commit_ready_o(commit_ready_o), .commit_overlap_o(commit_overlap_o),
    .check_v_i(check_v_i), .check_ready_o(check_ready_o), .done_v_o(done_v_o),
    .cleared_cnt_o(cleared_cnt_o), .total_lines_o(total_lines_o),
    .busy_o(busy_o), .rd_row_i(rd_row_i), .rd_data_o(rd_data_o)
  );

  typedef struct {
    logic [15:0] shape;
    int          x;
    int          y;
    int          ov;
  } vec_t;

  vec_t        vecs [13];
  logic [W-1:0] model [H];
  int          tot_model;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_ov_q [$];
  int          exp_done_q [$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_commit(input logic [15:0] s, input int x, input int y);
    bit ov = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (s[i*4+j]) begin
          int r = y + i;
          int c = x + j;
          if (r >= 0 && r < H && c >= 0 && c < W) begin
            if (model[r][c]) ov = 1'b1;
            model[r][c] = 1'b1;
          end
        end
    return ov;
  endfunction

  // Reference clear: keep non-full rows, pack them against the bottom.
  function automatic int model_check();
    logic [W-1:0] nm [H];
    int w = H - 1;
    int k = 0;
    for (int r = 0; r < H; r++) nm[r] = '0;
    for (int r = H - 1; r >= 0; r--) begin
      if (model[r] == '1) k++;
      else begin
        nm[w] = model[r];
        w--;
      end
    end
    for (int r = 0; r < H; r++) model[r] = nm[r];
    return k;
  endfunction

  task automatic model_zero();
    for (int r = 0; r < H; r++) model[r] = '0;
  endtask

  task automatic compare_scene(input string tag);
    for (int r = 0; r < H; r++) begin
      @(negedge clk_i);
      rd_row_i = 5'(r);
      #1;
      chk($sformatf("row%0d %s", r, tag), rd_data_o, model[r]);
    end
  endtask

  task automatic peek(input int r, input logic [15:0] exp, input string tag);
    @(negedge clk_i);
    rd_row_i = 5'(r);
    #1;
    chk($sformatf("peek row%0d %s", r, tag), rd_data_o, exp);
  endtask

  // exp_ov < 0 means take the expected overlap from the reference playfield.
  task automatic do_commit(input logic [15:0] s, input int x, input int y, input int exp_ov);
    bit ov_m;
    @(negedge clk_i);
    commit_v_i = 1'b1;
    commit_shape_i = s;
    commit_x_i = 5'(x);
    commit_y_i = 6'(y);
    #1;
    chk("commit_ready", commit_ready_o, 1);
    ov_m = model_commit(s, x, y);
    exp_ov_q.push_back((exp_ov < 0) ? int'(ov_m) : exp_ov);
    @(negedge clk_i);
    commit_v_i = 1'b0;
    #1;
    chk($sformatf("commit_overlap s=%h x=%0d y=%0d", s, x, y), commit_overlap_o, exp_ov_q.pop_front());
    @(negedge clk_i);
    #1;
    chk("overlap_pulse_end", commit_overlap_o, 0);
  endtask

  task automatic fill_row(input int r);
    for (int q = 0; q < 4; q++) do_commit(16'h000F, q * 4, r, -1);
  endtask

  task automatic do_clear();
    @(negedge clk_i);
    clear_v_i = 1'b1;
    commit_v_i = 1'b1;
    check_v_i = 1'b1;
    commit_shape_i = 16'hFFFF;
    commit_x_i = 5'd0;
    commit_y_i = 6'd0;
    #1;
    chk("clear commit_ready", commit_ready_o, 0);
    chk("clear check_ready", check_ready_o, 0);
    @(negedge clk_i);
    clear_v_i = 1'b0;
    commit_v_i = 1'b0;
    check_v_i = 1'b0;
    model_zero();
    tot_model = 0;
    #1;
    chk("clear total", total_lines_o, 0);
    chk("clear overlap", commit_overlap_o, 0);
    chk("clear busy", busy_o, 0);
    compare_scene("after clear");
  endtask

  task automatic do_check(input bit poke_clear);
    int n;
    int k;
    k = model_check();
    tot_model = (tot_model + k > TMAX) ? TMAX : tot_model + k;
    @(negedge clk_i);
    check_v_i = 1'b1;
    #1;
    chk("check_ready", check_ready_o, 1);
    exp_done_q.push_back(H + 2 * k + 1);
    @(negedge clk_i);
    check_v_i = 1'b0;
    n = 1;
    #1;
    chk("check busy", busy_o, 1);
    while (!done_v_o && n < 400) begin
      @(negedge clk_i);
      n++;
      clear_v_i = (poke_clear && n == 3);
      #1;
      if (poke_clear && n == 3) begin
        chk("busy commit_ready", commit_ready_o, 0);
        chk("busy check_ready", check_ready_o, 0);
      end
    end
    clear_v_i = 1'b0;
    if (done_v_o) begin
      chk("done_cycle", n, exp_done_q.pop_front());
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done_v_o within %0d cycles, expected one at %0d", n, exp_done_q.pop_front());
    end
    @(negedge clk_i);
    #1;
    chk("done pulse end", done_v_o, 0);
    chk("idle after done", busy_o, 0);
    chk("cleared_cnt", cleared_cnt_o, k);
    chk("total_lines", total_lines_o, tot_model);
    compare_scene("after check");
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    vecs[0]  = '{16'h0027,   2,  30, 0};
    vecs[1]  = '{16'h0027,   2,  30, 1};
    vecs[2]  = '{16'hFFFF,  -1,  -2, 0};
    vecs[3]  = '{16'h0001,  15,  31, 0};
    vecs[4]  = '{16'h000F,  15,  31, 1};
    vecs[5]  = '{16'h1000,   0,  29, 0};
    vecs[6]  = '{16'hFFFF, -16, -16, 0};
    vecs[7]  = '{16'h0F0F,   0,  29, 0};
    vecs[8]  = '{16'h0F0F,   4,  29, 0};
    vecs[9]  = '{16'h0F0F,   8,  29, 0};
    vecs[10] = '{16'h0F0F,  12,  29, 0};
    vecs[11] = '{16'h0001,   0,  30, 0};
    vecs[12] = '{16'h0001,  15,  28, 0};

    reset_n_i = 1'b0; clear_v_i = 1'b0; commit_v_i = 1'b0; check_v_i = 1'b0;
    commit_shape_i = '0; commit_x_i = '0; commit_y_i = '0; rd_row_i = '0;
    model_zero();
    tot_model = 0;

    // Reset state
    repeat (3) @(negedge clk_i);
    #1;
    chk("reset busy", busy_o, 0);
    chk("reset done", done_v_o, 0);
    chk("reset overlap", commit_overlap_o, 0);
    chk("reset cleared", cleared_cnt_o, 0);
    chk("reset total", total_lines_o, 0);
    chk("reset check_ready", check_ready_o, 1);
    compare_scene("in reset");
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // T-shape, repeat overlap, clipping
    for (int v = 0; v < 7; v++) begin
      do_commit(vecs[v].shape, vecs[v].x, vecs[v].y, vecs[v].ov);
      if (v == 1) begin
        peek(30, 16'h001C, "T");
        peek(31, 16'h0008, "T");
      end
      if (v == 2) begin
        peek(0, 16'h0007, "clip");
        peek(1, 16'h0007, "clip");
      end
    end
    compare_scene("table A");
    do_clear();

    // Two full rows with partial rows interleaved
    for (int v = 7; v < 13; v++) do_commit(vecs[v].shape, vecs[v].x, vecs[v].y, vecs[v].ov);
    compare_scene("table B");
    do_check(1'b1);
    peek(31, 16'h0001, "collapse");
    peek(30, 16'h8000, "collapse");

    // Empty scene check, then commit and check requested together
    do_clear();
    do_check(1'b0);
    @(negedge clk_i);
    commit_v_i = 1'b1; check_v_i = 1'b1;
    commit_shape_i = 16'h0001; commit_x_i = 5'd5; commit_y_i = 6'd10;
    #1;
    chk("both commit_ready", commit_ready_o, 1);
    chk("both check_ready", check_ready_o, 0);
    exp_ov_q.push_back(int'(model_commit(16'h0001, 5, 10)));
    @(negedge clk_i);
    commit_v_i = 1'b0; check_v_i = 1'b0;
    #1;
    chk("both overlap", commit_overlap_o, exp_ov_q.pop_front());
    chk("both busy", busy_o, 0);
    peek(10, 16'h0020, "both");

    // Lifetime counter saturation on a 2-bit counter
    fill_row(31);
    do_check(1'b0);
    fill_row(31);
    fill_row(30);
    do_check(1'b0);
    fill_row(31);
    do_check(1'b0);
    do_clear();

    // Reset in the middle of a check
    fill_row(31);
    do_check(1'b0);
    fill_row(31);
    fill_row(20);
    @(negedge clk_i);
    check_v_i = 1'b1;
    @(negedge clk_i);
    check_v_i = 1'b0;
    repeat (9) @(negedge clk_i);
    reset_n_i = 1'b0;
    #1;
    chk("midreset busy", busy_o, 0);
    chk("midreset done", done_v_o, 0);
    chk("midreset total", total_lines_o, 0);
    chk("midreset cleared", cleared_cnt_o, 0);
    model_zero();
    tot_model = 0;
    compare_scene("mid reset");
    @(negedge clk_i);
    reset_n_i = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      #1;
      if (done_v_o) saw_done = 1'b1;
    end
    chk("no done after reset", saw_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
